// File: rtl/sd_spi_master_if.sv
`default_nettype none
// ============================================================================
// Module : sd_spi_master_if
// Brief  : Byte handshake and SPI pin bundle for sd_spi_master.
// Rev    : 1.0  initial release
// ============================================================================
interface sd_spi_master_if;
  logic       fast_i;
  logic       cs_en_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       busy_o;
  logic       SD_CS;
  logic       SD_CLK;
  logic       SD_MOSI;
  logic       SD_MISO;

  // master: the SPI engine itself; slave: the client issuing bytes and the card
  modport master (
    input  fast_i, cs_en_i, tx_data_i, tx_valid_i, SD_MISO,
    output tx_ready_o, rx_data_o, rx_valid_o, busy_o, SD_CS, SD_CLK, SD_MOSI
  );
  modport slave (
    output fast_i, cs_en_i, tx_data_i, tx_valid_i, SD_MISO,
    input  tx_ready_o, rx_data_o, rx_valid_o, busy_o, SD_CS, SD_CLK, SD_MOSI
  );
endinterface
`default_nettype wire

// File: rtl/sd_spi_master.sv
`default_nettype none
// ============================================================================
// Module : sd_spi_master
// Brief  : Byte-wide SPI mode-0 master for SD cards with slow/fast SCK divider.
//          Optional macro SD_SPI_INIT_CLOCKS_EN adds 80 slow SCK periods after reset.
// Rev    : 1.0  initial release
// ============================================================================
module sd_spi_master #(
  parameter int unsigned SLOW_DIV = 62,
  parameter int unsigned FAST_DIV = 1
) (
  input  wire logic       CLOCK_50,
  input  wire logic       RESET,
  sd_spi_master_if.master bus
);
  localparam logic [7:0] C_SLOW = 8'(SLOW_DIV);
  localparam logic [7:0] C_FAST = 8'(FAST_DIV);

`ifdef SD_SPI_INIT_CLOCKS_EN
  typedef enum logic [2:0] {IDLE = 3'd0, LOW = 3'd1, HIGH = 3'd2, DONE = 3'd3, INIT = 3'd4} state_t;
  localparam state_t C_RESET_STATE = INIT;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
  localparam state_t C_RESET_STATE = IDLE;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rx_data;
  logic       r_cs;
  logic       r_init_hi;
  logic [6:0] r_init_per;
  logic       w_phase_end;

  assign w_phase_end = (r_cnt == 8'd0);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) r_state <= C_RESET_STATE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.tx_valid_i) w_next = LOW;
      LOW:  if (w_phase_end) w_next = HIGH;
      HIGH: if (w_phase_end) w_next = (r_bit == 3'd0) ? DONE : LOW;
      DONE: w_next = IDLE;
`ifdef SD_SPI_INIT_CLOCKS_EN
      INIT: if (w_phase_end && r_init_hi && (r_init_per == 7'd79)) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Divider counts down from DIV, so every SCK phase lasts DIV+1 cycles
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_cnt      <= C_SLOW;
      r_div      <= C_SLOW;
      r_bit      <= 3'd0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_rx_data  <= 8'h00;
      r_cs       <= 1'b1;
      r_init_hi  <= 1'b0;
      r_init_per <= 7'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cs <= ~bus.cs_en_i;
          if (bus.tx_valid_i) begin
            r_div <= bus.fast_i ? C_FAST : C_SLOW;
            r_cnt <= bus.fast_i ? C_FAST : C_SLOW;
            r_tx  <= bus.tx_data_i;
            r_bit <= 3'd7;
          end
        end
        LOW: begin
          if (w_phase_end) begin
            r_cnt <= r_div;
            r_rx  <= {r_rx[6:0], bus.SD_MISO};
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            r_cnt <= r_div;
            r_tx  <= {r_tx[6:0], 1'b0};
            r_bit <= r_bit - 3'd1;
            if (r_bit == 3'd0) r_rx_data <= r_rx;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
`ifdef SD_SPI_INIT_CLOCKS_EN
        INIT: begin
          if (w_phase_end) begin
            r_cnt     <= r_div;
            r_init_hi <= ~r_init_hi;
            if (r_init_hi) r_init_per <= r_init_per + 7'd1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs are gated by RESET so the pins go safe immediately, not one edge later
  assign bus.tx_ready_o = ~RESET & (r_state == IDLE);
  assign bus.busy_o     = ~RESET & (r_state != IDLE);
  assign bus.rx_valid_o = ~RESET & (r_state == DONE);
  assign bus.rx_data_o  = r_rx_data;
  assign bus.SD_CS      = RESET | r_cs;
`ifdef SD_SPI_INIT_CLOCKS_EN
  assign bus.SD_CLK     = ~RESET & ((r_state == HIGH) | ((r_state == INIT) & r_init_hi));
`else
  assign bus.SD_CLK     = ~RESET & (r_state == HIGH);
`endif
  assign bus.SD_MOSI    = (RESET | ((r_state != LOW) & (r_state != HIGH))) ? 1'b1 : r_tx[7];

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_master.sv
`default_nettype none
// ============================================================================
// Module : tb_sd_spi_master
// Brief  : Self-checking bench for sd_spi_master: directed cases plus random bytes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sd_spi_master;
  localparam int SLOW = 62;
  localparam int FAST = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_spi_master_if bus();

  sd_spi_master #(.SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Card model: loopback, or shift out a stored byte MSB first, one bit per SCK rise
  logic       loopback  = 1'b1;
  logic [7:0] miso_byte = 8'h00;
  int         mon_rises = 0;
  logic [2:0] miso_idx;
  assign miso_idx    = 3'(7 - mon_rises);
  assign bus.SD_MISO = loopback ? bus.SD_MOSI : miso_byte[miso_idx];

  int         change_at  = -1;
  logic [7:0] change_val = 8'h00;
  int         cs_at      = -1;
  logic       drop_valid = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic post_reset(input string tag);
`ifdef SD_SPI_INIT_CLOCKS_EN
    int n, r, bad;
    logic prev;
    n = 0; r = 0; bad = 0; prev = 1'b0;
    while (bus.tx_ready_o !== 1'b1 && n < 80 * 2 * (SLOW + 1) + 50) begin
      @(negedge clk);
      n++;
      if (bus.SD_CLK === 1'b1 && !prev) r++;
      prev = bus.SD_CLK;
      if (bus.tx_ready_o !== 1'b1 && (bus.SD_CS !== 1'b1 || bus.SD_MOSI !== 1'b1 || bus.busy_o !== 1'b1)) bad++;
    end
    check({tag, "_init_rises"}, r, 80);
    check({tag, "_init_pins"}, bad, 0);
    check({tag, "_init_ready"}, bus.tx_ready_o, 1);
`else
    @(negedge clk);
    check({tag, "_ready"}, bus.tx_ready_o, 1);
    check({tag, "_idle_pins"}, {bus.busy_o, bus.SD_CLK, bus.SD_MOSI}, 3'b001);
`endif
  endtask

  task automatic apply_reset(input string tag, input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    check({tag, "_cs"}, bus.SD_CS, 1);
    check({tag, "_clk"}, bus.SD_CLK, 0);
    check({tag, "_mosi"}, bus.SD_MOSI, 1);
    check({tag, "_ready"}, bus.tx_ready_o, 0);
    check({tag, "_rxv"}, bus.rx_valid_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_rxdata"}, bus.rx_data_o, 8'h00);
    rst = 1'b0;
    post_reset(tag);
  endtask

  // Called at a negedge; the handshake happens on the posedge after the returning negedge
  task automatic start_byte(input logic [7:0] tx, input logic fast, input logic lb, input logic [7:0] mb);
    int n;
    bus.tx_data_i  = tx;
    bus.fast_i     = fast;
    loopback       = lb;
    miso_byte      = mb;
    mon_rises      = 0;
    bus.tx_valid_i = 1'b1;
    n = 0;
    while (bus.tx_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_ready", bus.tx_ready_o, 1);
  endtask

  task automatic watch_byte(input int div, input logic [7:0] exp_mosi, input logic [7:0] exp_rx, input string tag);
    int k, run, bad_runs, busy_bad, cs_changes, budget;
    logic prev_clk, cs0, seen, clk_at_done;
    logic [7:0] mosi_bits, rxd;
    k = 0; run = 0; bad_runs = 0; busy_bad = 0; cs_changes = 0;
    prev_clk = 1'b0; cs0 = bus.SD_CS; seen = 1'b0; clk_at_done = 1'b1;
    mosi_bits = 8'h00; rxd = 8'hxx;
    budget = 16 * (div + 1) + 20;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      if (k == 1 && drop_valid) bus.tx_valid_i = 1'b0;
      if (k == change_at) bus.tx_data_i = change_val;
      if (k == cs_at) bus.cs_en_i = ~bus.cs_en_i;
      if (bus.busy_o !== 1'b1 || bus.tx_ready_o !== 1'b0) busy_bad++;
      if (bus.SD_CS !== cs0) cs_changes++;
      if (bus.rx_valid_o === 1'b1) begin
        seen = 1'b1;
        rxd = bus.rx_data_o;
        clk_at_done = bus.SD_CLK;
        if (prev_clk && run != div + 1) bad_runs++;
      end else if (bus.SD_CLK === prev_clk) begin
        run++;
      end else begin
        if (run != div + 1) bad_runs++;
        if (bus.SD_CLK === 1'b1) begin
          mon_rises++;
          mosi_bits = {mosi_bits[6:0], bus.SD_MOSI};
        end
        run = 1;
        prev_clk = bus.SD_CLK;
      end
    end
    check({tag, "_latency"}, k, 16 * (div + 1) + 1);
    check({tag, "_rises"}, mon_rises, 8);
    check({tag, "_mosi"}, mosi_bits, exp_mosi);
    check({tag, "_rxdata"}, rxd, exp_rx);
    check({tag, "_phase_len"}, bad_runs, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_cs_stable"}, cs_changes, 0);
    check({tag, "_done_clk"}, clk_at_done, 0);
  endtask

  task automatic after_byte(input logic [7:0] exp_rx, input string tag);
    @(negedge clk);
    check({tag, "_pulse_end"}, bus.rx_valid_o, 0);
    check({tag, "_idle_ready"}, bus.tx_ready_o, 1);
    check({tag, "_hold"}, bus.rx_data_o, exp_rx);
  endtask

  initial begin
    logic [7:0] t, m;
    logic       f, l;
    int         n, r;
    logic       prev;

    bus.fast_i = 1'b0; bus.cs_en_i = 1'b0; bus.tx_data_i = 8'h00; bus.tx_valid_i = 1'b0;

    apply_reset("reset", 3);

    // Fast loopback of A5
    start_byte(8'hA5, 1'b1, 1'b1, 8'h00);
    watch_byte(FAST, 8'hA5, 8'hA5, "fast_a5");
    after_byte(8'hA5, "fast_a5");

    // Slow FF with MISO held low
    start_byte(8'hFF, 1'b0, 1'b0, 8'h00);
    watch_byte(SLOW, 8'hFF, 8'h00, "slow_ff");
    after_byte(8'h00, "slow_ff");

    // Random bytes: the card either echoes MOSI or returns its own byte
    for (int i = 0; i < 8; i++) begin
      t = 8'($urandom);
      m = 8'($urandom);
      f = ($urandom_range(0, 3) != 0);
      l = 1'($urandom_range(0, 1));
      start_byte(t, f, l, m);
      watch_byte(f ? FAST : SLOW, t, l ? t : m, "rand");
      after_byte(l ? t : m, "rand");
    end

    // Back-to-back with tx_valid held and tx_data changed mid-byte
    start_byte(8'h40, 1'b1, 1'b1, 8'h00);
    drop_valid = 1'b0; change_at = 10; change_val = 8'h00;
    watch_byte(FAST, 8'h40, 8'h40, "b2b0");
    @(negedge clk);
    check("b2b_second_accept", bus.tx_ready_o, 1);
    check("b2b_gap_rxv", bus.rx_valid_o, 0);
    mon_rises = 0; drop_valid = 1'b1; change_at = -1;
    watch_byte(FAST, 8'h00, 8'h00, "b2b1");
    after_byte(8'h00, "b2b1");

    // Chip select toggled mid-byte only moves after the byte completes
    bus.cs_en_i = 1'b1;
    repeat (2) @(negedge clk);
    check("cs_low", bus.SD_CS, 0);
    start_byte(8'h5A, 1'b1, 1'b1, 8'h00);
    cs_at = 17;
    watch_byte(FAST, 8'h5A, 8'h5A, "cs");
    cs_at = -1;
    @(negedge clk);
    check("cs_idle_hold", bus.SD_CS, 0);
    @(negedge clk);
    check("cs_release", bus.SD_CS, 1);

    // Reset pulsed after the 4th SCK rise aborts the byte silently
    start_byte(8'h3C, 1'b1, 1'b1, 8'h00);
    n = 0; r = 0; prev = 1'b0;
    while (r < 4 && n < 200) begin
      @(negedge clk);
      n++;
      bus.tx_valid_i = 1'b0;
      if (bus.SD_CLK === 1'b1 && !prev) r++;
      prev = bus.SD_CLK;
    end
    check("abort_fourth_rise", r, 4);
    apply_reset("abort", 1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rx_valid_o !== 1'b0) n++;
    end
    check("abort_no_rxv", n, 0);
    check("abort_ready", bus.tx_ready_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sd_spi_master.md
SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 SHALL have parameter SLOW_DIV, default 62, SCK half-period minus one in CLOCK_50 cycles for init speed (50 MHz/126 ≈ 397 kHz).
REQ-002 SHALL have parameter FAST_DIV, default 1, SCK half-period minus one for data speed (12.5 MHz).
REQ-003 SHALL have port CLOCK_50  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous and active-high; the top drives it from ~RESET_N.
REQ-005 SHALL have port fast_i  in  1  selects FAST_DIV (1) or SLOW_DIV (0), sampled at byte start.
REQ-006 SHALL have port cs_en_i  in  1  1 = assert card select (SD_CS low).
REQ-007 SHALL have port tx_data_i  in  8  byte to transmit, MSB first.
REQ-008 SHALL have port tx_valid_i  in  1  byte request.
REQ-009 SHALL have port tx_ready_o  out  1  block accepts a byte this cycle.
REQ-010 SHALL have port rx_data_o  out  8  byte received from SD_MISO, held until the next completed byte.
REQ-011 SHALL have port rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
REQ-012 SHALL have port busy_o  out  1  high while not IDLE.
REQ-013 SHALL have ports SD_CS out 1, SD_CLK out 1, SD_MOSI out 1, SD_MISO in 1, all pin-level SPI mode 0.

Function
REQ-014 SHALL implement states IDLE, LOW, HIGH, DONE (plus INIT when SD_SPI_INIT_CLOCKS_EN is defined).
REQ-015 SHALL assert tx_ready_o only in IDLE; the transfer starts on the cycle tx_valid_i && tx_ready_o.
REQ-016 SHALL, at the handshake, latch tx_data_i into the shift register and latch the divider (FAST_DIV if fast_i else SLOW_DIV), then enter LOW.
REQ-017 SHALL, in LOW, drive SD_CLK=0 and SD_MOSI=current MSB for DIV+1 cycles, then enter HIGH.
REQ-018 SHALL, on entering HIGH, drive SD_CLK=1 and sample SD_MISO into the receive register LSB (left shift).
REQ-019 SHALL, after DIV+1 cycles in HIGH, shift tx data left and return to LOW for bits 7..1, or enter DONE after bit 0.
REQ-020 SHALL, in DONE, drive SD_CLK=0, update rx_data_o, pulse rx_valid_o for one cycle, and return to IDLE next cycle.
REQ-021 SHALL pulse rx_valid_o exactly 16*(DIV+1)+1 cycles after the handshake cycle.
REQ-022 SHALL drive SD_MOSI=1 and SD_CLK=0 whenever IDLE.
REQ-023 SHALL update SD_CS (= ~cs_en_i, registered) only in IDLE; changes mid-byte take effect after DONE.
REQ-024 SHALL ignore tx_valid_i while busy, with no queuing, and SHALL accept back-to-back bytes with one IDLE cycle between them.
REQ-025 SHALL keep the divider counter at 8 bits; DIV values above 255 are illegal.

Reset
REQ-026 SHALL, while RESET=1, force SD_CS=1, SD_CLK=0, SD_MOSI=1, tx_ready_o=0, rx_valid_o=0, busy_o=0, rx_data_o=8'h00, and set state to IDLE (INIT when the macro is defined).
REQ-027 SHALL, when RESET asserts mid-byte, abort the byte on the next edge with no rx_valid_o pulse.

Configuration
REQ-028 SHALL, when SD_SPI_INIT_CLOCKS_EN is defined, enter INIT after reset: 80 SCK periods at SLOW_DIV with SD_CS=1 and SD_MOSI=1, busy_o=1, tx_ready_o=0, then IDLE.
REQ-029 SHALL, when SD_SPI_INIT_CLOCKS_EN is undefined, omit INIT and assert tx_ready_o on the first cycle after RESET deasserts.

Verification
REQ-030 SHALL check: fast_i=1, send 8'hA5, SD_MISO loops back SD_MOSI -> 8 SCK pulses, MOSI bits 1,0,1,0,0,1,0,1, rx_data_o=8'hA5, rx_valid_o 33 cycles after the handshake.
REQ-031 SHALL check: fast_i=0, send 8'hFF with SD_MISO=0 -> SCK high/low 63 cycles each, rx_data_o=8'h00 at cycle 1009.
REQ-032 SHALL check: tx_valid_i held high for two bytes 8'h40, 8'h00 -> second byte accepted one cycle after the first rx_valid_o, and a mid-byte tx_data_i change is ignored.
REQ-033 SHALL check: cs_en_i toggled at bit 3 -> SD_CS changes only after DONE.
REQ-034 SHALL check: RESET pulsed after the 4th SCK rise -> SD_CLK=0, SD_CS=1, no rx_valid_o pulse.
REQ-035 SHALL check, with SD_SPI_INIT_CLOCKS_EN defined: exactly 80 SCK rises with SD_CS=1, then tx_ready_o=1.
